// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame link (uart_frame_tx_fsm / uart_frame_rx_fsm).
//   uart_state_t      : frame FSM states
//   PARITY_*          : parity mode constants, compared against the PARITY parameter
//   baud_div/half_div : clocks per bit and the mid-bit sample offset
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic [31:0] PARITY_NONE = "NONE";
  localparam logic [31:0] PARITY_EVEN = "EVEN";
  localparam logic [31:0] PARITY_ODD  = "ODD";

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned baud);
    return baud_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
//   clk, rst_n : clock, synchronous active-low reset (all flops reset to 1 = idle line)
//   line       : asynchronous serial input
//   line_sync  : synchronized line level
//   fall       : high for one cycle when the synchronized line goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic line_sync,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      hist <= sync;
    end
  end

  assign line_sync = sync;
  assign fall      = hist & ~sync;

endmodule

// File: rtl/uart_frame_rx_fsm.sv
// UART frame receiver: oversamples uart_rx, validates the start bit at mid-bit,
// assembles FRAME_WD data bits LSB first, checks optional parity and the stop bit.
//   clk, rst_n   : clock, synchronous active-low reset
//   uart_rx      : asynchronous serial line, idle high
//   data_frame   : last received data, bit0 = first bit on the line
//   rx_done      : one-cycle strobe, data_frame and flags updated
//   parity_error : parity mismatch on last frame (0 when PARITY = "NONE")
//   frame_error  : stop bit sampled low on last frame
module uart_frame_rx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCE = 50_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter logic [31:0] PARITY        = "NONE",
  parameter int unsigned FRAME_WD      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  output logic [FRAME_WD-1:0] data_frame,
  output logic                rx_done,
  output logic                parity_error,
  output logic                frame_error
);

  localparam int unsigned BAUD_CNT = baud_div(CLK_FREQUENCE, BAUD_RATE);
  localparam int unsigned HALF     = half_div(CLK_FREQUENCE, BAUD_RATE);
  localparam int unsigned CW       = $clog2(BAUD_CNT);
  localparam int unsigned IW       = (FRAME_WD > 1) ? $clog2(FRAME_WD) : 1;
  localparam bit          HAS_PAR  = (PARITY != PARITY_NONE);
  localparam bit          ODD_PAR  = (PARITY == PARITY_ODD);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_WD - 1);

  generate
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
      $error("uart_frame_rx_fsm: PARITY must be NONE, EVEN or ODD");
    end
    if (BAUD_CNT < 4) begin : g_bad_baud
      $error("uart_frame_rx_fsm: CLK_FREQUENCE/BAUD_RATE must be at least 4");
    end
    if (FRAME_WD < 1 || FRAME_WD > 16) begin : g_bad_width
      $error("uart_frame_rx_fsm: FRAME_WD must be 1..16");
    end
  endgenerate

  logic line;
  logic fall;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .line      (uart_rx),
    .line_sync (line),
    .fall      (fall)
  );

  uart_state_t         state,   state_nxt;
  logic [CW-1:0]       cnt,     cnt_nxt;
  logic [IW-1:0]       idx,     idx_nxt;
  logic [FRAME_WD-1:0] shift,   shift_nxt;
  logic                par_bit, par_bit_nxt;
  logic                stop_hit;
  logic                par_err;

  assign par_err = HAS_PAR ? (par_bit != (ODD_PAR ? ~^shift : ^shift)) : 1'b0;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nxt     = idx;
    shift_nxt   = shift;
    par_bit_nxt = par_bit;
    stop_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (fall) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt == CNT_MID && line) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_DATA;
          idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (cnt == CNT_MID) shift_nxt[idx] = line;
        if (cnt == CNT_LAST) begin
          if (idx == IDX_LAST) state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt == CNT_MID)  par_bit_nxt = line;
        if (cnt == CNT_LAST) state_nxt   = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid-stop so the next start edge is caught with half a bit of margin.
        if (cnt == CNT_MID) begin
          stop_hit  = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      data_frame   <= '0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      par_bit <= par_bit_nxt;
      rx_done <= stop_hit;
      if (stop_hit) begin
        data_frame   <= shift;
        parity_error <= par_err;
        frame_error  <= ~line;
      end
    end
  end

endmodule
